alien_bomb: RTL and testbench

Enemy-fire manager for the Space Invaders playfield: the downward counterpart of the player's bullet. It owns a pool of three bombs, periodically asks the alien grid for a launch point, and drops each bomb toward the player by `speed` pixels per frame. It retires a bomb when it leaves the bottom of the screen or when the external collision logic reports a hit. It also renders all live bombs as solid rectangles into the pixel pipeline.

---
 rtl/alien_bomb.sv | 182 ++++++++++++++++++
 tb/tb_alien_bomb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alien_bomb.sv
// alien_bomb: three-slot enemy bomb pool. Requests launch points from the alien grid,
// drops live bombs by `speed` each frame, retires them on exit or hit, and renders them.

module alien_bomb_slot #(
    parameter int CW     = 16,
    parameter int V_RES  = 480,
    parameter int BOMB_W = 4,
    parameter int BOMB_H = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_i,
    input  logic                 kill_i,
    input  logic                 load_i,
    input  logic [7:0]           speed_i,
    input  logic signed [CW-1:0] load_x_i,
    input  logic signed [CW-1:0] load_y_i,
    input  logic signed [CW-1:0] screen_x_i,
    input  logic signed [CW-1:0] screen_y_i,
    output logic                 active_o,
    output logic signed [CW-1:0] x_o,
    output logic signed [CW-1:0] y_o,
    output logic                 in_rect_o
);
    localparam logic signed [CW:0] VRES_X = (CW+1)'(V_RES);
    localparam logic signed [CW:0] BW_X   = (CW+1)'(BOMB_W);
    localparam logic signed [CW:0] BH_X   = (CW+1)'(BOMB_H);

    logic                 active_q, active_d;
    logic signed [CW-1:0] x_q, x_d, y_q, y_d;
    logic signed [CW:0]   y_ext, sum, sx, sy, x_lo, x_hi, y_hi;

    always_comb begin
        y_ext    = {y_q[CW-1], y_q};
        sum      = y_ext + $signed({1'b0, CW'(speed_i)});
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        // Hit wins over both launch and fall; a hit on an idle slot falls through.
        if (kill_i && active_q) begin
            active_d = 1'b0;
        end else if (load_i) begin
            active_d = 1'b1;
            x_d      = load_x_i;
            y_d      = load_y_i;
        end else if (move_i && active_q) begin
            if (sum >= VRES_X) active_d = 1'b0;
            else               y_d      = sum[CW-1:0];
        end
    end

    always_comb begin
        sx        = {screen_x_i[CW-1], screen_x_i};
        sy        = {screen_y_i[CW-1], screen_y_i};
        x_lo      = {x_q[CW-1], x_q};
        x_hi      = x_lo + BW_X;
        y_hi      = y_ext + BH_X;
        in_rect_o = active_q && (sx >= x_lo) && (sx < x_hi) && (sy >= y_ext) && (sy < y_hi);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
endmodule

module alien_bomb #(
    parameter int SCREEN_CORDW = 16,
    parameter int COLR_BITS    = 4,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BOMB_W       = 4,
    parameter int BOMB_H       = 12,
    parameter int RELOAD       = 32,
    parameter logic [COLR_BITS-1:0] BOMB_COLR = 4'hF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame,
    input  logic                           en,
    input  logic [7:0]                     speed,
    output logic                           drop_req,
    output logic [7:0]                     drop_rand,
    input  logic                           drop_valid,
    input  logic                           drop_empty,
    input  logic signed [SCREEN_CORDW-1:0] drop_x,
    input  logic signed [SCREEN_CORDW-1:0] drop_y,
    input  logic                           hit,
    input  logic [1:0]                     hit_slot,
    input  logic signed [SCREEN_CORDW-1:0] screen_x,
    input  logic signed [SCREEN_CORDW-1:0] screen_y,
    output logic [2:0]                     bomb_active,
    output logic [3*SCREEN_CORDW-1:0]      bomb_x,
    output logic [3*SCREEN_CORDW-1:0]      bomb_y,
    output logic                           drawing,
    output logic [COLR_BITS-1:0]           pixel
);
    localparam int CW  = SCREEN_CORDW;
    localparam int CDW = ($clog2(RELOAD+1) > 6) ? $clog2(RELOAD+1) : 6;

    logic [CDW-1:0]       cooldown_q, cooldown_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 drawing_q, drawing_d;
    logic [COLR_BITS-1:0] pixel_q, pixel_d;
    logic [2:0]           active, load_sel, kill, in_rect;
    logic                 move, handshake;

    // Request is a pure function of state and en, so dropping en withdraws it at once
    // and a handshake (cooldown reload) lowers it on the following cycle.
    assign move      = frame & en;
    assign drop_req  = en && (cooldown_q == '0) && !(&active);
    assign handshake = drop_req & drop_valid;
    assign drop_rand = drop_req ? lfsr_q : 8'h00;

    always_comb begin
        lfsr_d = lfsr_q;
        if (move && !drop_req)
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        cooldown_d = cooldown_q;
        if (handshake)
            cooldown_d = CDW'(RELOAD);
        else if (move && cooldown_q != '0)
            cooldown_d = cooldown_q - CDW'(1);
        load_sel = 3'b000;
        if (handshake && !drop_empty) begin
            if      (!active[0]) load_sel = 3'b001;
            else if (!active[1]) load_sel = 3'b010;
            else if (!active[2]) load_sel = 3'b100;
        end
        drawing_d = |in_rect;
        pixel_d   = drawing_d ? BOMB_COLR : '0;
    end

    for (genvar i = 0; i < 3; i++) begin : g_slot
        assign kill[i] = hit && (hit_slot == 2'(i));
        alien_bomb_slot #(.CW(CW), .V_RES(V_RES), .BOMB_W(BOMB_W), .BOMB_H(BOMB_H)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .move_i     (move),
            .kill_i     (kill[i]),
            .load_i     (load_sel[i]),
            .speed_i    (speed),
            .load_x_i   (drop_x),
            .load_y_i   (drop_y),
            .screen_x_i (screen_x),
            .screen_y_i (screen_y),
            .active_o   (active[i]),
            .x_o        (bomb_x[i*CW +: CW]),
            .y_o        (bomb_y[i*CW +: CW]),
            .in_rect_o  (in_rect[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cooldown_q <= CDW'(RELOAD);
            lfsr_q     <= 8'hA5;
            drawing_q  <= 1'b0;
            pixel_q    <= '0;
        end else begin
            cooldown_q <= cooldown_d;
            lfsr_q     <= lfsr_d;
            drawing_q  <= drawing_d;
            pixel_q    <= pixel_d;
        end
    end

    assign bomb_active = active;
    assign drawing     = drawing_q;
    assign pixel       = pixel_q;
endmodule

// File: tb/tb_alien_bomb.sv
// Randomized bench for alien_bomb: a frame-level reference model predicts every cycle's
// outputs into a queue; a monitor pops and compares against the DUT.

module tb_alien_bomb;
    localparam int CW = 16, RELOAD = 32, VRES = 480, BW = 4, BH = 12;
    localparam int NCYC = 20000;

    logic clk = 1'b0, rst = 1'b0, frame = 1'b0, en = 1'b0;
    logic [7:0] speed = 8'd0;
    logic drop_valid = 1'b0, drop_empty = 1'b0, hit = 1'b0;
    logic [1:0] hit_slot = 2'd0;
    logic signed [CW-1:0] drop_x = '0, drop_y = '0, screen_x = '0, screen_y = '0;
    logic drop_req, drawing;
    logic [7:0] drop_rand;
    logic [2:0] bomb_active;
    logic [3*CW-1:0] bomb_x, bomb_y;
    logic [3:0] pixel;

    alien_bomb dut (
        .clk(clk), .rst(rst), .frame(frame), .en(en), .speed(speed),
        .drop_req(drop_req), .drop_rand(drop_rand), .drop_valid(drop_valid),
        .drop_empty(drop_empty), .drop_x(drop_x), .drop_y(drop_y),
        .hit(hit), .hit_slot(hit_slot), .screen_x(screen_x), .screen_y(screen_y),
        .bomb_active(bomb_active), .bomb_x(bomb_x), .bomb_y(bomb_y),
        .drawing(drawing), .pixel(pixel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          req;
        logic [7:0]  rnd;
        logic [2:0]  act;
        logic [47:0] bx;
        logic [47:0] by;
        bit          draw;
        logic [3:0]  pix;
    } exp_t;
    exp_t sb[$];

    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want)
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        else
            n_pass++;
    endtask

    // Reference model: per-slot live flag and position as plain integers.
    bit         m_act[3];
    int         m_x[3], m_y[3];
    int         m_cool;
    logic [7:0] m_lfsr;
    bit         m_draw;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        m_cool = RELOAD; m_lfsr = 8'hA5; m_draw = 0;
    endtask

    function automatic bit m_req();
        return en && (m_cool == 0) && !(m_act[0] && m_act[1] && m_act[2]);
    endfunction

    task automatic push_exp();
        exp_t e;
        e.cyc = cyc;
        e.req = m_req();
        e.rnd = e.req ? m_lfsr : 8'h00;
        for (int i = 0; i < 3; i++) begin
            e.act[i] = m_act[i];
            e.bx[i*16 +: 16] = m_x[i][15:0];
            e.by[i*16 +: 16] = m_y[i][15:0];
        end
        e.draw = m_draw;
        e.pix  = m_draw ? 4'hF : 4'h0;
        sb.push_back(e);
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit req, hs, mv;
        int ls;
        req = m_req();
        hs  = req && drop_valid;
        mv  = frame && en;
        m_draw = 0;
        for (int i = 0; i < 3; i++)
            if (m_act[i] && screen_x >= m_x[i] && screen_x < m_x[i] + BW &&
                screen_y >= m_y[i] && screen_y < m_y[i] + BH)
                m_draw = 1;
        if (mv && !req) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
        if (hs) m_cool = RELOAD;
        else if (mv && m_cool > 0) m_cool--;
        ls = -1;
        if (hs && !drop_empty)
            for (int i = 0; i < 3; i++) if (!m_act[i] && ls < 0) ls = i;
        for (int i = 0; i < 3; i++) begin
            if (hit && int'(hit_slot) == i && m_act[i]) m_act[i] = 0;
            else if (i == ls) begin m_act[i] = 1; m_x[i] = drop_x; m_y[i] = drop_y; end
            else if (m_act[i] && mv) begin
                if (m_y[i] + int'(speed) >= VRES) m_act[i] = 0;
                else m_y[i] = m_y[i] + int'(speed);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},    64'(drop_req),    64'd0);
        chk({tag, "_rand"},   64'(drop_rand),   64'd0);
        chk({tag, "_active"}, 64'(bomb_active), 64'd0);
        chk({tag, "_x"},      64'(bomb_x),      64'd0);
        chk({tag, "_y"},      64'(bomb_y),      64'd0);
        chk({tag, "_draw"},   64'(drawing),     64'd0);
        chk({tag, "_pixel"},  64'(pixel),       64'd0);
    endtask

    // Monitor: compares the prediction tagged with the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #3;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("drop_req",    64'(drop_req),    64'(e.req));
                chk("drop_rand",   64'(drop_rand),   64'(e.rnd));
                chk("bomb_active", 64'(bomb_active), 64'(e.act));
                chk("bomb_x",      64'(bomb_x),      64'(e.bx));
                chk("bomb_y",      64'(bomb_y),      64'(e.by));
                chk("drawing",     64'(drawing),     64'(e.draw));
                chk("pixel",       64'(pixel),       64'(e.pix));
            end
        end
    end

    initial begin
        int resp_wait, en_off, j;
        resp_wait = 0; en_off = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        rst = 1'b1; en = 1'b1; speed = 8'd10;
        model_reset();
        for (int c = 0; c < NCYC; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            if (c == NCYC / 2) begin
                // Asynchronous mid-run reset must clear state without a clock edge.
                rst = 1'b0;
                #1 chk_reset_outputs("midreset");
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b1;
                model_reset();
            end
            if (c % 400 == 0) speed = 8'($urandom_range(0, 60));
            if (en_off > 0) begin
                en_off--;
                if (en_off == 0) en = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                en = 1'b0; en_off = $urandom_range(5, 40);
            end
            frame = ($urandom_range(0, 2) == 0);
            hit = ($urandom_range(0, 24) == 0);
            hit_slot = 2'($urandom_range(0, 3));
            drop_valid = 1'b0; drop_empty = 1'b0;
            if (m_req()) begin
                if (resp_wait == 0) begin
                    drop_valid = 1'b1;
                    drop_empty = ($urandom_range(0, 4) == 0);
                    drop_x = CW'(int'($urandom_range(0, 660)) - 10);
                    drop_y = CW'(int'($urandom_range(0, 470)) - 20);
                    resp_wait = $urandom_range(0, 6);
                end else resp_wait--;
            end else if ($urandom_range(0, 39) == 0) begin
                drop_valid = 1'b1;
                drop_empty = 1'($urandom_range(0, 1));
                drop_x = CW'($urandom_range(0, 639));
                drop_y = CW'($urandom_range(0, 479));
            end
            j = $urandom_range(0, 2);
            if (m_act[j] && $urandom_range(0, 9) < 7) begin
                screen_x = CW'(m_x[j] + int'($urandom_range(0, 7)) - 2);
                screen_y = CW'(m_y[j] + int'($urandom_range(0, 15)) - 2);
            end else begin
                screen_x = CW'($urandom_range(0, 639));
                screen_y = CW'($urandom_range(0, 479));
            end
            push_exp();
            model_step();
        end
        repeat (3) @(posedge clk);
        #5 chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
